// File: rtl/int_source_dev.sv
// rtl/int_source_dev.sv - bus-slave interrupt source (PC match, periodic timer, external edge)
// Requests queue in a saturating pending counter; one assertion per ACK with a forced idle gap.
module int_source_dev #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7f20,
  parameter int          MAX_PEND   = 7,
  parameter int          PEND_W     = 3,
  parameter int          GAP_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_int_addr,
  input  logic [3:0]  m_int_byteen,
  input  logic [31:0] m_int_wdata,
  input  logic [31:0] m_int_raddr,
  output logic [31:0] m_int_rdata,
  input  logic        ext_req,
  output logic        interrupt
);

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int SUM_W = PEND_W + 2;

  localparam logic [29:0] ACK_WA = BASE_ADDR[31:2];
  localparam logic [29:0] TGT_WA = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0] PER_WA = BASE_ADDR[31:2] + 30'd2;
  localparam logic [29:0] CTL_WA = BASE_ADDR[31:2] + 30'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_val,
    input logic [31:0] wdata,
    input logic [3:0]  byteen
  );
    logic [31:0] r;
    r = old_val;
    for (int k = 0; k < 4; k++) begin
      if (byteen[k]) r[8*k +: 8] = wdata[8*k +: 8];
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               int_q, int_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [31:0]        target_pc_q, target_pc_d;
  logic [31:0]        period_q, period_d;
  logic [31:0]        tmr_cnt_q, tmr_cnt_d;
  logic               pc_en_q, pc_en_d;
  logic               tmr_en_q, tmr_en_d;
  logic               ext_en_q, ext_en_d;
  logic               ovf_q, ovf_d;
  logic               pc_armed_q, pc_armed_d;
  logic               ext_req_q, ext_req_d;

  logic        wr_en;
  logic        hit_ack, hit_tgt, hit_per, hit_ctl;
  logic [31:0] ctrl_rd, ctrl_wr_val;
  logic        pc_fire, tmr_run, tmr_fire, ext_fire;
  logic        ack_take, drop;
  logic [1:0]  nreq;
  logic [SUM_W-1:0] pend_sum;

  assign wr_en   = |m_int_byteen;
  assign hit_ack = wr_en && (m_int_addr[31:2] == ACK_WA);
  assign hit_tgt = wr_en && (m_int_addr[31:2] == TGT_WA);
  assign hit_per = wr_en && (m_int_addr[31:2] == PER_WA);
  assign hit_ctl = wr_en && (m_int_addr[31:2] == CTL_WA);

  assign ctrl_rd     = {23'b0, ovf_q, 5'b0, ext_en_q, tmr_en_q, pc_en_q};
  assign ctrl_wr_val = merge_bytes(ctrl_rd, m_int_wdata, m_int_byteen);

  // Register writes and request sources. Enables take their written value
  // in the write cycle, so clearing an enable suppresses that cycle's request.
  always_comb begin
    target_pc_d = target_pc_q;
    period_d    = period_q;
    pc_en_d     = pc_en_q;
    tmr_en_d    = tmr_en_q;
    ext_en_d    = ext_en_q;
    if (hit_tgt) target_pc_d = merge_bytes(target_pc_q, m_int_wdata, m_int_byteen);
    if (hit_per) period_d    = merge_bytes(period_q, m_int_wdata, m_int_byteen);
    if (hit_ctl) begin
      pc_en_d  = ctrl_wr_val[0];
      tmr_en_d = ctrl_wr_val[1];
      ext_en_d = ctrl_wr_val[2];
    end

    pc_fire    = pc_en_d && pc_armed_q && (macroscopic_pc[31:2] == target_pc_q[31:2]);
    pc_armed_d = pc_armed_q;
    if (pc_fire) pc_armed_d = 1'b0;
    if (hit_tgt) pc_armed_d = 1'b1;

    tmr_run   = tmr_en_d && (period_q != 32'd0);
    tmr_fire  = tmr_run && (tmr_cnt_q <= 32'd1);
    tmr_cnt_d = tmr_cnt_q;
    if (tmr_fire)     tmr_cnt_d = period_q;
    else if (tmr_run) tmr_cnt_d = tmr_cnt_q - 32'd1;
    if (hit_per)      tmr_cnt_d = period_d;

    ext_req_d = ext_req;
    ext_fire  = ext_en_d && ext_req && !ext_req_q;
  end

  // Pending counter: add requests, retire an acknowledged one, then saturate.
  always_comb begin
    nreq     = 2'(pc_fire) + 2'(tmr_fire) + 2'(ext_fire);
    ack_take = hit_ack && (state_q == S_ASSERT);
    pend_sum = SUM_W'(pend_q) + SUM_W'(nreq);
    if (ack_take && (pend_sum != '0)) pend_sum = pend_sum - SUM_W'(1);
    drop   = 1'b0;
    pend_d = pend_sum[PEND_W-1:0];
    if (pend_sum > SUM_W'(MAX_PEND)) begin
      drop   = 1'b1;
      pend_d = PEND_W'(MAX_PEND);
    end
    ovf_d = (ovf_q && !(hit_ctl && m_int_byteen[1] && m_int_wdata[8])) || drop;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    int_d   = int_q;
    case (state_q)
      S_IDLE: begin
        if (pend_d != '0) begin
          state_d = S_ASSERT;
          int_d   = 1'b1;
        end
      end
      S_ASSERT: begin
        if (hit_ack) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_CYCLES);
          int_d   = 1'b0;
        end
      end
      S_GAP: begin
        if (gap_q > GAP_W'(1)) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          gap_d = '0;
          if (pend_d != '0) begin
            state_d = S_ASSERT;
            int_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gap_d   = '0;
        int_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      int_q       <= 1'b0;
      pend_q      <= '0;
      target_pc_q <= '0;
      period_q    <= '0;
      tmr_cnt_q   <= '0;
      pc_en_q     <= 1'b0;
      tmr_en_q    <= 1'b0;
      ext_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
      pc_armed_q  <= 1'b0;
      ext_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      int_q       <= int_d;
      pend_q      <= pend_d;
      target_pc_q <= target_pc_d;
      period_q    <= period_d;
      tmr_cnt_q   <= tmr_cnt_d;
      pc_en_q     <= pc_en_d;
      tmr_en_q    <= tmr_en_d;
      ext_en_q    <= ext_en_d;
      ovf_q       <= ovf_d;
      pc_armed_q  <= pc_armed_d;
      ext_req_q   <= ext_req_d;
    end
  end

  always_comb begin
    m_int_rdata = 32'd0;
    if (m_int_raddr[31:2] == ACK_WA)      m_int_rdata = {{(32-PEND_W){1'b0}}, pend_q};
    else if (m_int_raddr[31:2] == TGT_WA) m_int_rdata = target_pc_q;
    else if (m_int_raddr[31:2] == PER_WA) m_int_rdata = period_q;
    else if (m_int_raddr[31:2] == CTL_WA) m_int_rdata = ctrl_rd;
  end

  assign interrupt = int_q;

  logic unused_bits;
  assign unused_bits = ^{m_int_addr[1:0], m_int_raddr[1:0], macroscopic_pc[1:0],
                         ctrl_wr_val[31:3]};

endmodule

// File: tb/tb_int_source_dev.sv
// tb/tb_int_source_dev.sv - directed bench for int_source_dev with a behavioural model
module tb_int_source_dev;

  localparam logic [31:0] BASE = 32'h0000_7f20;
  localparam logic [31:0] A_ACK = BASE;
  localparam logic [31:0] A_TGT = BASE + 32'd4;
  localparam logic [31:0] A_PER = BASE + 32'd8;
  localparam logic [31:0] A_CTL = BASE + 32'd12;
  localparam int MAXP = 7;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic [31:0] macroscopic_pc, m_int_addr, m_int_wdata, m_int_raddr, m_int_rdata;
  logic [3:0]  m_int_byteen;
  logic        ext_req, interrupt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  int_source_dev dut (
    .clk_in(clk), .sys_rstn(sys_rstn), .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen), .m_int_wdata(m_int_wdata),
    .m_int_raddr(m_int_raddr), .m_int_rdata(m_int_rdata),
    .ext_req(ext_req), .interrupt(interrupt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: plain integers for the queue depth and the idle gap.
  int          m_pend, m_gap;
  bit          m_int, m_pc_en, m_tmr_en, m_ext_en, m_ovf, m_armed, m_ext_prev;
  logic [31:0] m_tgt, m_per, m_cnt;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == A_ACK) return 32'(m_pend);
    if (w == A_TGT) return m_tgt;
    if (w == A_PER) return m_per;
    if (w == A_CTL) return {23'b0, m_ovf, 5'b0, m_ext_en, m_tmr_en, m_pc_en};
    return 32'd0;
  endfunction

  task automatic model_step();
    logic [31:0] w, cv;
    bit wr, pe, te, ee, ack;
    int n, p;
    if (!sys_rstn) begin
      m_pend = 0; m_gap = 0; m_int = 0; m_pc_en = 0; m_tmr_en = 0; m_ext_en = 0;
      m_ovf = 0; m_armed = 0; m_ext_prev = 0; m_tgt = 0; m_per = 0; m_cnt = 0;
      return;
    end
    wr = |m_int_byteen;
    w  = {m_int_addr[31:2], 2'b00};
    cv = {23'b0, m_ovf, 5'b0, m_ext_en, m_tmr_en, m_pc_en};
    pe = m_pc_en; te = m_tmr_en; ee = m_ext_en;
    if (wr && w == A_CTL) begin
      cv = merge(cv, m_int_wdata, m_int_byteen);
      pe = cv[0]; te = cv[1]; ee = cv[2];
    end
    n = 0;
    if (pe && m_armed && macroscopic_pc[31:2] == m_tgt[31:2]) begin
      n++;
      m_armed = 0;
    end
    if (te && m_per != 0) begin
      if (m_cnt <= 1) begin n++; m_cnt = m_per; end
      else m_cnt = m_cnt - 1;
    end
    if (ee && ext_req && !m_ext_prev) n++;
    m_ext_prev = ext_req;
    if (wr && w == A_TGT) begin m_tgt = merge(m_tgt, m_int_wdata, m_int_byteen); m_armed = 1; end
    if (wr && w == A_PER) begin m_per = merge(m_per, m_int_wdata, m_int_byteen); m_cnt = m_per; end
    if (wr && w == A_CTL && m_int_byteen[1] && m_int_wdata[8]) m_ovf = 0;
    m_pc_en = pe; m_tmr_en = te; m_ext_en = ee;
    ack = wr && (w == A_ACK) && m_int;
    p = m_pend + n - (ack ? 1 : 0);
    if (p < 0) p = 0;
    if (p > MAXP) begin p = MAXP; m_ovf = 1; end
    m_pend = p;
    if (m_int) begin
      if (ack) begin m_int = 0; m_gap = GAP; end
    end else begin
      if (m_gap > 0) m_gap--;
      if (m_gap == 0 && m_pend > 0) m_int = 1;
    end
  endtask

  always begin
    @(posedge clk);
    model_step();
    #2;
    chk("irq_model", {31'b0, interrupt}, {31'b0, m_int});
    chk("rdata_model", m_int_rdata, mread(m_int_raddr));
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_int_addr = a; m_int_wdata = d; m_int_byteen = be;
    @(negedge clk);
    m_int_byteen = 4'h0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    m_int_raddr = a;
    #1;
    chk(name, m_int_rdata, exp);
    m_int_raddr = A_ACK;
  endtask

  task automatic pulse_ext();
    ext_req = 1'b1; step();
    ext_req = 1'b0; step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int rises, last, ack_at, k;
    bit prev;
    sys_rstn = 1'b0; macroscopic_pc = 0; m_int_addr = 0; m_int_wdata = 0;
    m_int_byteen = 0; m_int_raddr = A_ACK; ext_req = 0;
    step(2);
    sys_rstn = 1'b1;
    step();
    chk("reset_irq", {31'b0, interrupt}, 32'd0);
    rd_chk("reset_pend", A_ACK, 32'd0);
    rd_chk("reset_ctrl", A_CTL, 32'd0);

    // PC trigger fires once per arming
    wr(A_TGT, 32'h3008, 4'hf);
    wr(A_CTL, 32'h1, 4'hf);
    rd_chk("t1_tgt", A_TGT, 32'h3008);
    chk("t1_pre", {31'b0, interrupt}, 32'd0);
    macroscopic_pc = 32'h300a; step();
    chk("t1_rise", {31'b0, interrupt}, 32'd1);
    macroscopic_pc = 32'h0;
    wr(A_ACK, 32'h0, 4'hf);
    chk("t1_ack", {31'b0, interrupt}, 32'd0);
    step(3);
    macroscopic_pc = 32'h3008; step(3);
    chk("t1_no_rearm", {31'b0, interrupt}, 32'd0);
    macroscopic_pc = 32'h0;

    // ACK by byte lane at an unaligned address; zero byteen is no write
    wr(A_CTL, 32'h4, 4'hf);
    pulse_ext();
    chk("t2_irq", {31'b0, interrupt}, 32'd1);
    rd_chk("t2_pend1", A_ACK, 32'd1);
    m_int_addr = 32'h7f22; m_int_byteen = 4'h0; step();
    chk("t2_be0", {31'b0, interrupt}, 32'd1);
    wr(32'h7f22, 32'h0, 4'b0001);
    chk("t2_ack", {31'b0, interrupt}, 32'd0);
    rd_chk("t2_pend0", A_ACK, 32'd0);
    wr(A_CTL, 32'h0, 4'hf);
    step(3);

    // periodic timer, acked two cycles after each rise
    wr(A_PER, 32'd10, 4'hf);
    wr(A_CTL, 32'h2, 4'hf);
    prev = 0; rises = 0; last = -1; ack_at = -1;
    for (int c = 0; c < 45; c++) begin
      if (c == ack_at) begin m_int_addr = A_ACK; m_int_byteen = 4'hf; end
      else m_int_byteen = 4'h0;
      step();
      if (interrupt && !prev) begin
        if (rises > 0) chk("t3_period", 32'(c - last), 32'd10);
        last = c; rises++; ack_at = c + 2;
      end
      prev = interrupt;
    end
    m_int_byteen = 4'h0;
    chk("t3_rises", 32'(rises), 32'd4);
    wr(A_PER, 32'd0, 4'hf);
    for (int i = 0; i < 3; i++) if (interrupt) begin wr(A_ACK, 0, 4'hf); step(3); end
    prev = interrupt; rises = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (interrupt && !prev) rises++;
      prev = interrupt;
    end
    chk("t3_period0", 32'(rises), 32'd0);
    wr(A_CTL, 32'h0, 4'hf);

    // queued requests and the idle gap between assertions
    wr(A_CTL, 32'h4, 4'hf);
    pulse_ext(); pulse_ext(); pulse_ext();
    rd_chk("t4_pend3", A_ACK, 32'd3);
    for (int i = 0; i < 3; i++) begin
      wr(A_ACK, 32'h0, 4'hf);
      chk("t4_drop", {31'b0, interrupt}, 32'd0);
      k = 0;
      while (!interrupt && k < 10) begin step(); k++; end
      if (i < 2) chk("t4_gap_ok", 32'(k >= GAP && k < 10), 32'd1);
      else chk("t4_final_irq", {31'b0, interrupt}, 32'd0);
    end
    rd_chk("t4_pend0", A_ACK, 32'd0);

    // saturation and sticky overflow
    for (int i = 0; i < 9; i++) pulse_ext();
    rd_chk("t5_pend7", A_ACK, 32'd7);
    rd_chk("t5_ovf", A_CTL, 32'h104);
    wr(A_CTL, 32'h104, 4'hf);
    rd_chk("t5_ovf_clr", A_CTL, 32'h004);
    chk("t5_irq", {31'b0, interrupt}, 32'd1);

    // async reset while asserted
    for (int i = 0; i < 5; i++) begin wr(A_ACK, 32'h0, 4'hf); step(3); end
    rd_chk("t6_pend2", A_ACK, 32'd2);
    chk("t6_irq", {31'b0, interrupt}, 32'd1);
    sys_rstn = 1'b0;
    #1;
    chk("t6_async_drop", {31'b0, interrupt}, 32'd0);
    step(2);
    sys_rstn = 1'b1;
    step();
    rd_chk("t6_ack0", A_ACK, 32'd0);
    rd_chk("t6_tgt0", A_TGT, 32'd0);
    rd_chk("t6_per0", A_PER, 32'd0);
    rd_chk("t6_ctl0", A_CTL, 32'd0);

    // byte-lane merge
    wr(A_PER, 32'hAABBCCDD, 4'b0101);
    rd_chk("merge_per", A_PER, 32'h00BB00DD);
    wr(A_TGT, 32'h11223344, 4'b1010);
    rd_chk("merge_tgt", A_TGT, 32'h11003300);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
